// File: rtl/main_pkg.sv
// Shared definitions for the stream load feeder.
// Holds the default stream/address widths and the run-control FSM state type.
package main_pkg;

    localparam int unsigned DATAW_DEF = 32;
    localparam int unsigned ADDRW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous per-stream operand buffer.
// Ports: clk, rst_n (async active-low), push/push_data (write side),
//        pop/head (read side; head is the current oldest word),
//        full, empty, count (occupancy, 0..DEPTH).
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/stream_load_feeder.sv
// Stream load feeder: fetches two operand vectors (vin0 at base0, vin1 at base1)
// from word-addressed memory with interleaved reads, buffers each stream in a
// stream_fifo and presents aligned pairs to a kernel.
// Ports: clk, rst (async active-low); start/nelem/base0/base1 (run setup);
//        mem_rd_req/mem_rd_addr/mem_rd_gnt (read request, held until granted);
//        mem_rd_valid/mem_rd_data (in-order responses);
//        vin0_stream_load/vin1_stream_load (operands), stall (0 = pair consumed),
//        sink_stall (downstream back-pressure); busy, done (one-cycle pulse).
// Optional: define STREAM_LOAD_FEEDER_PERF_EN to add perf_stall_cnt, a saturating
//           count of busy cycles with stall=1, cleared on accepted start.
module stream_load_feeder
    import main_pkg::*;
#(
    parameter int unsigned DATAW      = DATAW_DEF,
    parameter int unsigned ADDRW      = ADDRW_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] nelem,
    input  logic [ADDRW-1:0] base0,
    input  logic [ADDRW-1:0] base1,
    output logic             mem_rd_req,
    output logic [ADDRW-1:0] mem_rd_addr,
    input  logic             mem_rd_gnt,
    input  logic             mem_rd_valid,
    input  logic [DATAW-1:0] mem_rd_data,
    output logic [DATAW-1:0] vin0_stream_load,
    output logic [DATAW-1:0] vin1_stream_load,
    output logic             stall,
    input  logic             sink_stall,
    output logic             busy,
    output logic             done
`ifdef STREAM_LOAD_FEEDER_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned NW = ADDRW + 1;

    state_t           state;
    logic [ADDRW-1:0] nelem_q, base0_q, base1_q;
    logic [ADDRW-1:0] req_idx, pop_cnt;
    logic [NW-1:0]    issue_cnt, gnt_cnt, total_req;
    logic             req_sel, rsp_sel, rsp_en;
    logic [CW-1:0]    resv0, resv1, cnt0, cnt1;
    logic [CW:0]      occ0, occ1;
    logic             full0, full1, empty0, empty1;
    logic [DATAW-1:0] head0, head1, last0, last1;
    logic             grant, can_issue, issue_now;
    logic             push0, push1, pop, last_pop;

    assign total_req = {nelem_q, 1'b0};
    assign grant     = mem_rd_req && mem_rd_gnt;

    // Credit: buffered words plus requests raised but not yet answered
    assign occ0      = (CW+1)'(cnt0) + (CW+1)'(resv0);
    assign occ1      = (CW+1)'(cnt1) + (CW+1)'(resv1);
    assign can_issue = (state == FETCH) && (issue_cnt != total_req) &&
                       ((req_sel ? occ1 : occ0) < (CW+1)'(FIFO_DEPTH));
    assign issue_now = (!mem_rd_req || mem_rd_gnt) && can_issue;

    // Responses alternate between the streams; rsp_en drops stale data after reset
    assign push0 = rsp_en && mem_rd_valid && !rsp_sel && (!full0 || pop);
    assign push1 = rsp_en && mem_rd_valid &&  rsp_sel && (!full1 || pop);

    assign pop      = !empty0 && !empty1 && !sink_stall;
    assign stall    = !pop;
    assign last_pop = pop && (state != IDLE) && ((pop_cnt + ADDRW'(1)) == nelem_q);

    // Heads drive the kernel directly on a pop; otherwise hold the last pair
    assign vin0_stream_load = pop ? head0 : last0;
    assign vin1_stream_load = pop ? head1 : last1;

    stream_fifo #(.WIDTH(DATAW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push0),
        .push_data (mem_rd_data),
        .pop       (pop),
        .head      (head0),
        .full      (full0),
        .empty     (empty0),
        .count     (cnt0)
    );

    stream_fifo #(.WIDTH(DATAW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push1),
        .push_data (mem_rd_data),
        .pop       (pop),
        .head      (head1),
        .full      (full1),
        .empty     (empty1),
        .count     (cnt1)
    );

    // Run control, request channel and bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            nelem_q     <= '0;
            base0_q     <= '0;
            base1_q     <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            req_sel     <= 1'b0;
            req_idx     <= '0;
            issue_cnt   <= '0;
            gnt_cnt     <= '0;
            rsp_sel     <= 1'b0;
            rsp_en      <= 1'b0;
            resv0       <= '0;
            resv1       <= '0;
            pop_cnt     <= '0;
            last0       <= '0;
            last1       <= '0;
        end else begin
            done <= 1'b0;

            // Request is only replaced once the current one is granted
            if (!mem_rd_req || mem_rd_gnt) begin
                mem_rd_req <= can_issue;
                if (can_issue) begin
                    mem_rd_addr <= (req_sel ? base1_q : base0_q) + req_idx;
                    req_sel     <= !req_sel;
                    if (req_sel) req_idx <= req_idx + ADDRW'(1);
                    issue_cnt   <= issue_cnt + NW'(1);
                end
            end

            if (grant) gnt_cnt <= gnt_cnt + NW'(1);
            resv0 <= resv0 + CW'(issue_now && !req_sel) - CW'(push0);
            resv1 <= resv1 + CW'(issue_now &&  req_sel) - CW'(push1);
            if (push0 || push1) rsp_sel <= !rsp_sel;

            if (pop) begin
                last0   <= head0;
                last1   <= head1;
                pop_cnt <= pop_cnt + ADDRW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        nelem_q   <= nelem;
                        base0_q   <= base0;
                        base1_q   <= base1;
                        req_sel   <= 1'b0;
                        req_idx   <= '0;
                        issue_cnt <= '0;
                        gnt_cnt   <= '0;
                        rsp_sel   <= 1'b0;
                        rsp_en    <= 1'b1;
                        resv0     <= '0;
                        resv1     <= '0;
                        pop_cnt   <= '0;
                        if (nelem == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (last_pop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (grant && ((gnt_cnt + NW'(1)) == total_req)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STREAM_LOAD_FEEDER_PERF_EN
    // Saturating count of busy cycles in which the kernel is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else if (start && (state == IDLE)) begin
            perf_stall_cnt <= '0;
        end else if (busy && stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_load_feeder.sv
// Self-checking bench for stream_load_feeder: a queue-based memory with random
// grant/latency, and a reference model that lists the expected request
// addresses and operand pairs from base/nelem with plain arithmetic.
`timescale 1ns/1ps
module tb_stream_load_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] nelem, base0, base1;
    logic        mem_rd_req;
    logic [15:0] mem_rd_addr;
    logic        mem_rd_gnt;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [31:0] vin0_stream_load, vin1_stream_load;
    logic        stall;
    logic        sink_stall;
    logic        busy;
    logic        done;
`ifdef STREAM_LOAD_FEEDER_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    stream_load_feeder dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .nelem            (nelem),
        .base0            (base0),
        .base1            (base1),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_gnt       (mem_rd_gnt),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .vin0_stream_load (vin0_stream_load),
        .vin1_stream_load (vin1_stream_load),
        .stall            (stall),
        .sink_stall       (sink_stall),
        .busy             (busy),
        .done             (done)
`ifdef STREAM_LOAD_FEEDER_PERF_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    int          tests  = 0;
    int          failed = 0;
    int unsigned cyc    = 0;

    logic [15:0] exp_addr_q[$];
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [15:0] pipe_addr[$];
    int unsigned pipe_due[$];

    int unsigned gnt_pct = 100;
    int unsigned lat_max = 1;
    int          g_cnt, outst0, outst1, pairs, dones;
    logic [31:0] last0, last1;
    logic        held_valid;
    logic [15:0] held_addr;
    logic [15:0] seed;

    // Memory contents: a fixed function of address and per-run seed
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, a * 16'd7 + seed};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, then drive memory inputs after the edge
    task automatic tick();
        logic [15:0] a;
        logic [31:0] e0, e1;
        @(negedge clk);
        if (held_valid) begin
            chk("req_hold", 64'(mem_rd_req), 64'(1));
            chk("addr_hold", 64'(mem_rd_addr), 64'(held_addr));
        end
        held_valid = 1'b0;
        if (mem_rd_req && mem_rd_gnt) begin
            chk("req_expected", 64'(exp_addr_q.size() != 0), 64'(1));
            if (exp_addr_q.size() != 0) begin
                a = exp_addr_q.pop_front();
                chk("req_addr", 64'(mem_rd_addr), 64'(a));
            end
            if (g_cnt % 2 == 0) outst0++; else outst1++;
            g_cnt++;
            chk("credit", 64'((outst0 <= DEPTH) && (outst1 <= DEPTH)), 64'(1));
            pipe_addr.push_back(mem_rd_addr);
            pipe_due.push_back(cyc + $urandom_range(lat_max, 1));
        end else if (mem_rd_req) begin
            held_valid = 1'b1;
            held_addr  = mem_rd_addr;
        end
        if (sink_stall) chk("sink_blocks", 64'(stall), 64'(1));
        if (!stall) begin
            chk("pop_expected", 64'(exp0_q.size() != 0), 64'(1));
            if (exp0_q.size() != 0) begin
                e0 = exp0_q.pop_front();
                e1 = exp1_q.pop_front();
                chk("vin0", 64'(vin0_stream_load), 64'(e0));
                chk("vin1", 64'(vin1_stream_load), 64'(e1));
                last0 = e0;
                last1 = e1;
            end
            outst0--;
            outst1--;
            pairs++;
        end else begin
            chk("vin0_hold", 64'(vin0_stream_load), 64'(last0));
            chk("vin1_hold", 64'(vin1_stream_load), 64'(last1));
        end
        if (done) dones++;
        @(posedge clk);
        #1;
        cyc++;
        mem_rd_gnt = ($urandom_range(99, 0) < gnt_pct);
        if (pipe_addr.size() != 0 && pipe_due[0] <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_word(pipe_addr.pop_front());
            void'(pipe_due.pop_front());
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = $urandom;
        end
    endtask

    // Start a run and step until done, the abort point, or the cycle bound
    task automatic run(input int n, input logic [15:0] b0, input logic [15:0] b1,
                       input int unsigned gp, input int unsigned lm,
                       input int ss_from, input int ss_len, input int abort_at,
                       input int bound);
        seed = 16'($urandom);
        exp_addr_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(b0 + 16'(i));
            exp_addr_q.push_back(b1 + 16'(i));
            exp0_q.push_back(mem_word(b0 + 16'(i)));
            exp1_q.push_back(mem_word(b1 + 16'(i)));
        end
        gnt_pct = gp;
        lat_max = lm;
        g_cnt   = 0;
        outst0  = 0;
        outst1  = 0;
        pairs   = 0;
        dones   = 0;
        nelem   = 16'(n);
        base0   = b0;
        base1   = b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int c = 0; c < bound && dones == 0; c++) begin
            sink_stall = (c >= ss_from) && (c < ss_from + ss_len);
            if (abort_at >= 0 && pairs >= abort_at) break;
            tick();
        end
        sink_stall = 1'b0;
    endtask

    task automatic finish_run(input int n);
        chk("done_seen", 64'(dones), 64'(1));
        repeat (3) tick();
        chk("done_once", 64'(dones), 64'(1));
        chk("pair_count", 64'(pairs), 64'(n));
        chk("reqs_left", 64'(exp_addr_q.size()), 64'(0));
        chk("busy_end", 64'(busy), 64'(0));
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", 64'(mem_rd_req), 64'(0));
        chk("rst_stall", 64'(stall), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_vin0", 64'(vin0_stream_load), 64'(0));
        chk("rst_vin1", 64'(vin1_stream_load), 64'(0));
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        nelem        = '0;
        base0        = '0;
        base1        = '0;
        mem_rd_gnt   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        sink_stall   = 1'b0;
        seed         = 16'h1234;
        last0        = '0;
        last1        = '0;
        held_valid   = 1'b0;
        g_cnt = 0; outst0 = 0; outst1 = 0; pairs = 0; dones = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b1;
        repeat (2) tick();

        // Basic run: always-grant, one-cycle memory
        run(4, 16'h0100, 16'h0200, 100, 1, -1, 0, -1, 200);
        finish_run(4);

        // Zero-length run: done one cycle after start, never busy, no requests
        exp_addr_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        dones = 0;
        nelem = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_busy", 64'(busy), 64'(0));
        tick();
        chk("zero_done_clear", 64'(done), 64'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("zero_busy_after", 64'(busy), 64'(0));
        end

        // Long sink back-pressure mid-run
        run(16, 16'h1000, 16'h2000, 100, 1, 8, 20, -1, 500);
        finish_run(16);

        // Random grant and latency, addresses wrapping past 0xFFFF
        run(64, 16'hFFE0, 16'h7FF0, 50, 5, -1, 0, -1, 3000);
        finish_run(64);

        // Reset mid-run after three pairs, then a fresh short run
        run(8, 16'h0300, 16'h0400, 70, 3, -1, 0, 3, 500);
        chk("abort_point", 64'(pairs), 64'(3));
        rst        = 1'b0;
        held_valid = 1'b0;
        last0      = '0;
        last1      = '0;
        exp_addr_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        #1;
        chk_reset_vals();
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 40 && pipe_addr.size() != 0; i++) tick();
        chk("pipe_drained", 64'(pipe_addr.size()), 64'(0));
        repeat (4) tick();
        chk("stale_no_busy", 64'(busy), 64'(0));
        run(2, 16'h0500, 16'h0600, 100, 1, -1, 0, -1, 200);
        finish_run(2);

`ifdef STREAM_LOAD_FEEDER_PERF_EN
        // Stall counter: held back-pressure, then cleared by the next start
        run(8, 16'h0700, 16'h0800, 100, 1, 3, 12, -1, 500);
        finish_run(8);
        chk("perf_min", 64'(perf_stall_cnt >= 32'd10), 64'(1));
        exp_addr_q.delete();
        nelem = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("perf_clear", 64'(perf_stall_cnt), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
